// File: rtl/ssd1306_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ssd1306_pkg
// Description : Opcodes and decoder state encoding for the SSD1306 SPI sink.
// Revision    : 1.0 - initial release
// ============================================================================
package ssd1306_pkg;

    localparam logic [7:0] c_OP_COL_ADDR  = 8'h21;
    localparam logic [7:0] c_OP_PAGE_ADDR = 8'h22;
    localparam logic [7:0] c_OP_DISP_OFF  = 8'hAE;
    localparam logic [7:0] c_OP_DISP_ON   = 8'hAF;

    typedef enum logic [2:0] {
        S_CMD        = 3'd0,
        S_COL_START  = 3'd1,
        S_COL_END    = 3'd2,
        S_PAGE_START = 3'd3,
        S_PAGE_END   = 3'd4,
        S_SKIP1      = 3'd5
    } dec_state_t;

    // Opcodes that carry a single argument byte the sink does not interpret.
    function automatic logic is_skip_op(input logic [7:0] op);
        case (op)
            8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3,
            8'hD5, 8'hD9, 8'hDA, 8'hDB: is_skip_op = 1'b1;
            default:                    is_skip_op = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_slave_rx.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_rx
// Description : Pin synchronizers, SCK edge detect and mode-0 byte assembly.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_sck,
    input  logic       i_csn,
    input  logic       i_dc,
    input  logic       i_mosi,
    input  logic       i_rstn,
    output logic       o_core_rst,
    output logic [7:0] o_byte,
    output logic       o_dc,
    output logic       o_byte_valid
);

    // Bit order {rstn, csn, dc, sck, mosi}; display reset held asserted until the chain fills.
    localparam logic [4:0] c_SYNC_RST = 5'b01000;

    logic [4:0] r_sync1;
    logic [4:0] r_sync2;
    logic       r_sck_prev;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_shift;
    logic [7:0] r_byte;
    logic       r_dc;
    logic       r_byte_valid;

    logic       w_rstn_s;
    logic       w_csn_s;
    logic       w_dc_s;
    logic       w_sck_s;
    logic       w_mosi_s;
    logic       w_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= c_SYNC_RST;
            r_sync2 <= c_SYNC_RST;
        end else begin
            r_sync1 <= {i_rstn, i_csn, i_dc, i_sck, i_mosi};
            r_sync2 <= r_sync1;
        end
    end

    assign w_rstn_s   = r_sync2[4];
    assign w_csn_s    = r_sync2[3];
    assign w_dc_s     = r_sync2[2];
    assign w_sck_s    = r_sync2[1];
    assign w_mosi_s   = r_sync2[0];
    assign o_core_rst = rst | ~w_rstn_s;
    assign w_rise     = w_sck_s & ~r_sck_prev & ~w_csn_s;

    always_ff @(posedge clk) begin
        if (o_core_rst) begin
            r_sck_prev   <= 1'b0;
            r_bit_cnt    <= 3'd0;
            r_shift      <= 7'd0;
            r_byte       <= 8'd0;
            r_dc         <= 1'b0;
            r_byte_valid <= 1'b0;
        end else begin
            r_sck_prev   <= w_sck_s;
            r_byte_valid <= 1'b0;
            if (w_csn_s) begin
                r_bit_cnt <= 3'd0;
            end else if (w_rise) begin
                r_shift   <= {r_shift[5:0], w_mosi_s};
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_byte       <= {r_shift, w_mosi_s};
                    r_dc         <= w_dc_s;
                    r_byte_valid <= 1'b1;
                end
            end
        end
    end

    assign o_byte       = r_byte;
    assign o_dc         = r_dc;
    assign o_byte_valid = r_byte_valid;

endmodule
`default_nettype wire

// File: rtl/ssd1306_spi_sink.sv
`default_nettype none
// ============================================================================
// Module      : ssd1306_spi_sink
// Description : SSD1306-style SPI receiver feeding a page/column framebuffer.
// Revision    : 1.0 - initial release
// ============================================================================
module ssd1306_spi_sink
    import ssd1306_pkg::*;
#(
    parameter int COLS  = 128,
    parameter int PAGES = 8
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       oled_rstn_in,
    input  logic       oled_csn_in,
    input  logic       oled_dc_in,
    input  logic       oled_clk_in,
    input  logic       oled_mosi_in,
    output logic       fb_we_out,
    output logic [9:0] fb_addr_out,
    output logic [7:0] fb_data_out,
    output logic       cmd_stb_out,
    output logic [7:0] cmd_byte_out,
    output logic       display_on_out,
    output logic       frame_done_out
);

    localparam int         c_COL_W  = (COLS  > 1) ? $clog2(COLS)  : 1;
    localparam int         c_PAGE_W = (PAGES > 1) ? $clog2(PAGES) : 1;
    localparam logic [9:0] c_COLS_A = 10'(COLS);

    logic                w_core_rst;
    logic [7:0]          w_rx_byte;
    logic                w_rx_dc;
    logic                w_rx_valid;

    dec_state_t          r_state, w_state_next;
    logic [c_COL_W-1:0]  r_col, r_col_start, r_col_end;
    logic [c_COL_W-1:0]  w_col_next, w_col_start_next, w_col_end_next;
    logic [c_PAGE_W-1:0] r_page, r_page_start, r_page_end;
    logic [c_PAGE_W-1:0] w_page_next, w_page_start_next, w_page_end_next;
    logic                r_disp, w_disp_next;
    logic                r_fb_we, w_fb_we_next;
    logic [9:0]          r_fb_addr, w_fb_addr_next;
    logic [7:0]          r_fb_data, w_fb_data_next;
    logic                r_cmd_stb, w_cmd_stb_next;
    logic [7:0]          r_cmd_byte, w_cmd_byte_next;
    logic                r_frame_done, w_frame_done_next;

    logic [9:0]          w_ptr_addr;
    logic [c_COL_W-1:0]  w_col_inc;
    logic [c_PAGE_W-1:0] w_page_inc;
    logic [c_COL_W-1:0]  w_arg_col;
    logic [c_PAGE_W-1:0] w_arg_page;

    spi_slave_rx u_rx (
        .clk          (clk_in),
        .rst          (reset_in),
        .i_sck        (oled_clk_in),
        .i_csn        (oled_csn_in),
        .i_dc         (oled_dc_in),
        .i_mosi       (oled_mosi_in),
        .i_rstn       (oled_rstn_in),
        .o_core_rst   (w_core_rst),
        .o_byte       (w_rx_byte),
        .o_dc         (w_rx_dc),
        .o_byte_valid (w_rx_valid)
    );

    assign w_ptr_addr = 10'(r_page) * c_COLS_A + 10'(r_col);
    assign w_col_inc  = (r_col == c_COL_W'(COLS - 1)) ? '0 : r_col + c_COL_W'(1);
    assign w_page_inc = (r_page == c_PAGE_W'(PAGES - 1)) ? '0 : r_page + c_PAGE_W'(1);
    assign w_arg_col  = w_rx_byte[c_COL_W-1:0];
    assign w_arg_page = w_rx_byte[c_PAGE_W-1:0];

    always_ff @(posedge clk_in) begin
        if (w_core_rst) begin
            r_state <= S_CMD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_col_next        = r_col;
        w_col_start_next  = r_col_start;
        w_col_end_next    = r_col_end;
        w_page_next       = r_page;
        w_page_start_next = r_page_start;
        w_page_end_next   = r_page_end;
        w_disp_next       = r_disp;
        w_fb_we_next      = 1'b0;
        w_fb_addr_next    = r_fb_addr;
        w_fb_data_next    = r_fb_data;
        w_cmd_stb_next    = 1'b0;
        w_cmd_byte_next   = r_cmd_byte;
        w_frame_done_next = 1'b0;

        if (w_rx_valid && w_rx_dc) begin
            // A data byte always lands, and abandons any half-received argument list.
            w_state_next   = S_CMD;
            w_fb_we_next   = 1'b1;
            w_fb_addr_next = w_ptr_addr;
            w_fb_data_next = w_rx_byte;
            if (r_col == r_col_end) begin
                w_col_next = r_col_start;
                if (r_page == r_page_end) begin
                    w_page_next       = r_page_start;
                    w_frame_done_next = 1'b1;
                end else begin
                    w_page_next = w_page_inc;
                end
            end else begin
                w_col_next = w_col_inc;
            end
        end else if (w_rx_valid) begin
            w_cmd_stb_next  = 1'b1;
            w_cmd_byte_next = w_rx_byte;
            case (r_state)
                S_CMD: begin
                    if (w_rx_byte == c_OP_COL_ADDR) begin
                        w_state_next = S_COL_START;
                    end else if (w_rx_byte == c_OP_PAGE_ADDR) begin
                        w_state_next = S_PAGE_START;
                    end else if (w_rx_byte == c_OP_DISP_OFF) begin
                        w_disp_next = 1'b0;
                    end else if (w_rx_byte == c_OP_DISP_ON) begin
                        w_disp_next = 1'b1;
                    end else if (is_skip_op(w_rx_byte)) begin
                        w_state_next = S_SKIP1;
                    end
                end
                S_COL_START: begin
                    w_col_start_next = w_arg_col;
                    w_col_next       = w_arg_col;
                    w_state_next     = S_COL_END;
                end
                S_COL_END: begin
                    w_col_end_next = w_arg_col;
                    w_state_next   = S_CMD;
                end
                S_PAGE_START: begin
                    w_page_start_next = w_arg_page;
                    w_page_next       = w_arg_page;
                    w_state_next      = S_PAGE_END;
                end
                S_PAGE_END: begin
                    w_page_end_next = w_arg_page;
                    w_state_next    = S_CMD;
                end
                default: begin
                    w_state_next = S_CMD;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_core_rst) begin
            r_col        <= '0;
            r_col_start  <= '0;
            r_col_end    <= c_COL_W'(COLS - 1);
            r_page       <= '0;
            r_page_start <= '0;
            r_page_end   <= c_PAGE_W'(PAGES - 1);
            r_disp       <= 1'b0;
            r_fb_we      <= 1'b0;
            r_fb_addr    <= 10'd0;
            r_fb_data    <= 8'd0;
            r_cmd_stb    <= 1'b0;
            r_cmd_byte   <= 8'd0;
            r_frame_done <= 1'b0;
        end else begin
            r_col        <= w_col_next;
            r_col_start  <= w_col_start_next;
            r_col_end    <= w_col_end_next;
            r_page       <= w_page_next;
            r_page_start <= w_page_start_next;
            r_page_end   <= w_page_end_next;
            r_disp       <= w_disp_next;
            r_fb_we      <= w_fb_we_next;
            r_fb_addr    <= w_fb_addr_next;
            r_fb_data    <= w_fb_data_next;
            r_cmd_stb    <= w_cmd_stb_next;
            r_cmd_byte   <= w_cmd_byte_next;
            r_frame_done <= w_frame_done_next;
        end
    end

    assign fb_we_out      = r_fb_we;
    assign fb_addr_out    = r_fb_addr;
    assign fb_data_out    = r_fb_data;
    assign cmd_stb_out    = r_cmd_stb;
    assign cmd_byte_out   = r_cmd_byte;
    assign display_on_out = r_disp;
    assign frame_done_out = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_ssd1306_spi_sink.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssd1306_spi_sink
// Description : Self-checking bench for ssd1306_spi_sink (vectors + random vs model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ssd1306_spi_sink;

    localparam int COLS  = 128;
    localparam int PAGES = 8;

    logic       clk_in = 1'b0;
    logic       reset_in, oled_rstn_in, oled_csn_in, oled_dc_in, oled_clk_in, oled_mosi_in;
    logic       fb_we_out, cmd_stb_out, display_on_out, frame_done_out;
    logic [9:0] fb_addr_out;
    logic [7:0] fb_data_out, cmd_byte_out;

    always #5 clk_in = ~clk_in;

    ssd1306_spi_sink #(.COLS(COLS), .PAGES(PAGES)) dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .oled_rstn_in   (oled_rstn_in),
        .oled_csn_in    (oled_csn_in),
        .oled_dc_in     (oled_dc_in),
        .oled_clk_in    (oled_clk_in),
        .oled_mosi_in   (oled_mosi_in),
        .fb_we_out      (fb_we_out),
        .fb_addr_out    (fb_addr_out),
        .fb_data_out    (fb_data_out),
        .cmd_stb_out    (cmd_stb_out),
        .cmd_byte_out   (cmd_byte_out),
        .display_on_out (display_on_out),
        .frame_done_out (frame_done_out)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_we, n_fd, n_cmd, last_addr, last_data, last_cmd, fd_addr;

    // Event capture: outputs are stable on the falling edge.
    always @(negedge clk_in) begin
        if (fb_we_out === 1'b1) begin
            n_we++;
            last_addr = int'(fb_addr_out);
            last_data = int'(fb_data_out);
            if (frame_done_out === 1'b1) fd_addr = int'(fb_addr_out);
        end
        if (frame_done_out === 1'b1) n_fd++;
        if (cmd_stb_out === 1'b1) begin
            n_cmd++;
            last_cmd = int'(cmd_byte_out);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: pointer window and pending-argument bookkeeping.
    int m_col, m_page, m_cs, m_ce, m_ps, m_pe, m_arg;
    bit m_disp;

    function automatic bit in_skip_list(input logic [7:0] b);
        logic [7:0] ops [9] = '{8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB};
        foreach (ops[i]) if (ops[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_col = 0; m_page = 0; m_cs = 0; m_ce = COLS - 1;
        m_ps = 0; m_pe = PAGES - 1; m_arg = 0; m_disp = 1'b0;
    endtask

    // m_arg: 0 none, 1 col start, 2 col end, 3 page start, 4 page end, 5 ignored arg
    task automatic model_byte(input bit dc, input logic [7:0] b,
                              output bit we, output int addr, output bit fd);
        we = 1'b0; addr = 0; fd = 1'b0;
        if (dc) begin
            we = 1'b1; addr = m_page * COLS + m_col; m_arg = 0;
            if (m_col == m_ce) begin
                m_col = m_cs;
                if (m_page == m_pe) begin m_page = m_ps; fd = 1'b1; end
                else m_page = (m_page + 1) % PAGES;
            end else begin
                m_col = (m_col + 1) % COLS;
            end
        end else begin
            case (m_arg)
                1: begin m_cs = int'(b) % COLS; m_col = m_cs; m_arg = 2; end
                2: begin m_ce = int'(b) % COLS; m_arg = 0; end
                3: begin m_ps = int'(b) % PAGES; m_page = m_ps; m_arg = 4; end
                4: begin m_pe = int'(b) % PAGES; m_arg = 0; end
                5: m_arg = 0;
                default: begin
                    if (b == 8'h21) m_arg = 1;
                    else if (b == 8'h22) m_arg = 3;
                    else if (b == 8'hAE) m_disp = 1'b0;
                    else if (b == 8'hAF) m_disp = 1'b1;
                    else if (in_skip_list(b)) m_arg = 5;
                end
            endcase
        end
    endtask

    task automatic send_bit(input logic dc, input logic b);
        oled_clk_in = 1'b0; oled_dc_in = dc; oled_mosi_in = b;
        repeat (2) @(negedge clk_in);
        oled_clk_in = 1'b1;
        repeat (2) @(negedge clk_in);
    endtask

    task automatic xfer(input logic dc, input logic [7:0] b);
        n_we = 0; n_fd = 0; n_cmd = 0;
        @(negedge clk_in);
        oled_csn_in = 1'b0;
        repeat (2) @(negedge clk_in);
        for (int i = 7; i >= 0; i--) send_bit(dc, b[i]);
        oled_clk_in = 1'b0;
        repeat (6) @(negedge clk_in);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        reset_in = 1'b1; oled_rstn_in = 1'b1; oled_csn_in = 1'b1;
        oled_dc_in = 1'b0; oled_clk_in = 1'b0; oled_mosi_in = 1'b0;
        repeat (3) @(negedge clk_in);
        reset_in = 1'b0;
        repeat (6) @(negedge clk_in);
        model_reset();
    endtask

    typedef struct {
        bit         dc;
        logic [7:0] b;
        bit         we;
        int         addr;
        bit         fd;
        bit         disp;
    } vec_t;

    vec_t tbl [25];

    initial begin
        bit we_m, fd_m;
        int addr_m;
        logic [7:0] rb;
        bit rdc;
        logic [7:0] ops [13] = '{8'h21, 8'h22, 8'hAE, 8'hAF, 8'h20, 8'h81, 8'h8D,
                                 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB};

        tbl[0]  = '{1'b1, 8'hA5, 1'b1,   0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 8'h5A, 1'b1,   1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 8'h21, 1'b0,   0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 8'h10, 1'b0,   0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 8'h11, 1'b0,   0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 8'h22, 1'b0,   0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 8'h02, 1'b0,   0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 8'h03, 1'b0,   0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 8'h01, 1'b1, 272, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 8'h02, 1'b1, 273, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 8'h03, 1'b1, 400, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 8'h04, 1'b1, 401, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 8'hAF, 1'b0,   0, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 8'h81, 1'b0,   0, 1'b0, 1'b1};
        tbl[14] = '{1'b0, 8'hAE, 1'b0,   0, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 8'hAE, 1'b0,   0, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 8'hAF, 1'b0,   0, 1'b0, 1'b1};
        tbl[17] = '{1'b1, 8'h3C, 1'b1, 272, 1'b0, 1'b1};
        tbl[18] = '{1'b0, 8'h21, 1'b0,   0, 1'b0, 1'b1};
        tbl[19] = '{1'b0, 8'h7F, 1'b0,   0, 1'b0, 1'b1};
        tbl[20] = '{1'b0, 8'h00, 1'b0,   0, 1'b0, 1'b1};
        tbl[21] = '{1'b1, 8'h11, 1'b1, 383, 1'b0, 1'b1};
        tbl[22] = '{1'b1, 8'h22, 1'b1, 256, 1'b0, 1'b1};
        tbl[23] = '{1'b1, 8'h33, 1'b1, 511, 1'b0, 1'b1};
        tbl[24] = '{1'b1, 8'h44, 1'b1, 384, 1'b1, 1'b1};

        n_we = 0; n_fd = 0; n_cmd = 0; last_addr = -1; last_data = -1; last_cmd = -1; fd_addr = -1;
        do_reset();

        chk("reset_fb_we", int'(fb_we_out), 0);
        chk("reset_fb_addr", int'(fb_addr_out), 0);
        chk("reset_fb_data", int'(fb_data_out), 0);
        chk("reset_cmd_stb", int'(cmd_stb_out), 0);
        chk("reset_cmd_byte", int'(cmd_byte_out), 0);
        chk("reset_display_on", int'(display_on_out), 0);
        chk("reset_frame_done", int'(frame_done_out), 0);

        foreach (tbl[i]) begin
            xfer(tbl[i].dc, tbl[i].b);
            chk($sformatf("vec%0d_we_count", i), n_we, int'(tbl[i].we));
            if (tbl[i].we) begin
                chk($sformatf("vec%0d_addr", i), last_addr, tbl[i].addr);
                chk($sformatf("vec%0d_data", i), last_data, int'(tbl[i].b));
            end
            chk($sformatf("vec%0d_frame_done", i), n_fd, int'(tbl[i].fd));
            chk($sformatf("vec%0d_cmd_count", i), n_cmd, int'(!tbl[i].dc));
            if (!tbl[i].dc) chk($sformatf("vec%0d_cmd_byte", i), last_cmd, int'(tbl[i].b));
            chk($sformatf("vec%0d_display_on", i), int'(display_on_out), int'(tbl[i].disp));
        end

        // Full-frame sweep with the default window.
        do_reset();
        begin
            int tot_we, tot_fd;
            tot_we = 0; tot_fd = 0; fd_addr = -1;
            for (int i = 0; i < COLS * PAGES; i++) begin
                xfer(1'b1, 8'(i));
                tot_we += n_we; tot_fd += n_fd;
            end
            chk("sweep_we_total", tot_we, COLS * PAGES);
            chk("sweep_last_addr", last_addr, COLS * PAGES - 1);
            chk("sweep_frame_done_count", tot_fd, 1);
            chk("sweep_frame_done_addr", fd_addr, COLS * PAGES - 1);
            xfer(1'b1, 8'hEE);
            chk("sweep_wrap_addr", last_addr, 0);
        end

        // Chip-select drop after 5 bits must discard the partial byte.
        do_reset();
        n_we = 0; n_cmd = 0;
        @(negedge clk_in);
        oled_csn_in = 1'b0;
        repeat (2) @(negedge clk_in);
        for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b1);
        oled_clk_in = 1'b0;
        oled_csn_in = 1'b1;
        repeat (6) @(negedge clk_in);
        chk("partial_no_strobe", n_cmd, 0);
        xfer(1'b0, 8'hAF);
        chk("partial_display_on", int'(display_on_out), 1);
        chk("partial_cmd_count", n_cmd, 1);
        chk("partial_cmd_byte", last_cmd, 8'hAF);
        chk("partial_no_write", n_we, 0);

        // Data byte inside an argument list aborts it.
        do_reset();
        xfer(1'b0, 8'h21);
        xfer(1'b1, 8'h55);
        chk("abort_we_count", n_we, 1);
        chk("abort_addr", last_addr, 0);
        chk("abort_data", last_data, 8'h55);
        xfer(1'b0, 8'hAF);
        chk("abort_fsm_idle", int'(display_on_out), 1);
        for (int i = 1; i < COLS; i++) xfer(1'b1, 8'h00);
        chk("abort_row_end_addr", last_addr, COLS - 1);
        xfer(1'b1, 8'h00);
        chk("abort_col_start_kept", last_addr, COLS);

        // Reset mid-byte: nothing emitted, receiver realigned.
        do_reset();
        n_we = 0; n_cmd = 0;
        @(negedge clk_in);
        oled_csn_in = 1'b0;
        repeat (2) @(negedge clk_in);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1);
        oled_clk_in = 1'b0;
        reset_in = 1'b1;
        repeat (2) @(negedge clk_in);
        reset_in = 1'b0;
        repeat (6) @(negedge clk_in);
        chk("midbyte_no_write", n_we, 0);
        xfer(1'b1, 8'h77);
        chk("midbyte_realign_addr", last_addr, 0);
        chk("midbyte_realign_data", last_data, 8'h77);

        // Display reset pin after moving the pointer to 300.
        do_reset();
        xfer(1'b0, 8'hAF);
        xfer(1'b0, 8'h21); xfer(1'b0, 8'd44); xfer(1'b0, 8'h7F);
        xfer(1'b0, 8'h22); xfer(1'b0, 8'h02); xfer(1'b0, 8'h07);
        xfer(1'b1, 8'h99);
        chk("rstn_pre_addr", last_addr, 300);
        chk("rstn_pre_display_on", int'(display_on_out), 1);
        @(negedge clk_in);
        oled_rstn_in = 1'b0;
        repeat (3) @(negedge clk_in);
        oled_rstn_in = 1'b1;
        repeat (6) @(negedge clk_in);
        chk("rstn_display_off", int'(display_on_out), 0);
        xfer(1'b1, 8'h5C);
        chk("rstn_post_addr", last_addr, 0);
        chk("rstn_post_display_on", int'(display_on_out), 0);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 120; i++) begin
            rdc = ($urandom_range(0, 1) == 1);
            if (rdc || $urandom_range(0, 3) == 0) rb = 8'($urandom);
            else rb = ops[$urandom_range(0, 12)];
            model_byte(rdc, rb, we_m, addr_m, fd_m);
            xfer(rdc, rb);
            chk($sformatf("rnd%0d_we_count", i), n_we, int'(we_m));
            if (we_m) begin
                chk($sformatf("rnd%0d_addr", i), last_addr, addr_m);
                chk($sformatf("rnd%0d_data", i), last_data, int'(rb));
            end
            chk($sformatf("rnd%0d_frame_done", i), n_fd, int'(fd_m));
            chk($sformatf("rnd%0d_cmd_count", i), n_cmd, int'(!rdc));
            if (!rdc) chk($sformatf("rnd%0d_cmd_byte", i), last_cmd, int'(rb));
            chk($sformatf("rnd%0d_display_on", i), int'(display_on_out), int'(m_disp));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
